mem_master: RTL and testbench

Host-side initiator for the memory controller's Valid/Ready request interface. It accepts single or burst read/write commands from on-chip logic and issues one controller request per word. Each request uses the Valid → Ready-low → Ready-high handshake. It drives the shared Data_in bus for writes and captures read data on completion. It sits between command-generating logic and the controller, and pairs with the RAM behind the controller.

---
 rtl/mem_master.sv | 198 +++++++++++++++++++
 tb/tb_mem_master.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// mem_master: host-side initiator for the memory controller's Valid/Ready
// request interface. Accepts single or burst read/write commands and issues
// one controller request per word. Each request raises Valid, waits for the
// controller to drop Ready, then waits for Ready to return high.
//
// Ports:
//   clk, reset          system clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready command handshake (cmd_ready high in IDLE only)
//   cmd_rw              1 = read, 0 = write
//   cmd_addr            start word address (16-bit, wraps modulo 2^16)
//   cmd_len             burst length minus one
//   wr_data/wr_pop      write-word source; source advances on wr_pop
//   rd_data/rd_valid    captured read word, one-cycle valid pulse per word
//   done/err            one-cycle pulse on burst completion / timeout abort
//   Valid, RW, Addr_in  request to controller
//   Data_in             shared data bus, driven only while Valid & ~RW
//   Ready               controller idle/complete
//
// state  | meaning
// IDLE   | no command in flight, cmd_ready high
// LAUNCH | Valid raised for current word, waiting for Ready to drop
// BUSY   | controller working on the word, waiting for Ready to rise
// GAP    | one cycle with Valid low, then next word or finish
module mem_master #(
   parameter int DWIDTH  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [15:0]       cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [DWIDTH-1:0] wr_data,
   output logic              wr_pop,
   output logic [DWIDTH-1:0] rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              err,
   output logic              Valid,
   output logic              RW,
   output logic [15:0]       Addr_in,
   inout  wire  [DWIDTH-1:0] Data_in,
   input  logic              Ready
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_BUSY   = 2'd2,
      S_GAP    = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        beats;
   logic [TW-1:0]     tmr;
   logic [DWIDTH-1:0] wdata_q;

   logic accept;
   logic next_beat;
   logic capture;
   logic abort;
   logic finish;
   logic tmr_reload;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      next_beat  = 1'b0;
      capture    = 1'b0;
      abort      = 1'b0;
      finish     = 1'b0;
      tmr_reload = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               accept     = 1'b1;
               tmr_reload = 1'b1;
               state_nxt  = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            // Ready already low on entry is legal: leave on the first edge.
            if (!Ready) begin
               tmr_reload = 1'b1;
               state_nxt  = S_BUSY;
            end else if (tmr == '0) begin
               abort     = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_BUSY: begin
            if (Ready) begin
               capture   = 1'b1;
               state_nxt = S_GAP;
            end else if (tmr == '0) begin
               abort     = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_GAP: begin
            if (beats != 8'd0) begin
               next_beat  = 1'b1;
               tmr_reload = 1'b1;
               state_nxt  = S_LAUNCH;
            end else begin
               finish    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign cmd_ready = (state == S_IDLE);

   // Registered request outputs and strobes. Pulses default low every cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Valid    <= 1'b0;
         RW       <= 1'b0;
         Addr_in  <= 16'h0000;
         beats    <= 8'd0;
         wdata_q  <= '0;
         wr_pop   <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         tmr      <= '0;
      end else begin
         wr_pop   <= 1'b0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;

         if (accept) begin
            Valid   <= 1'b1;
            RW      <= cmd_rw;
            Addr_in <= cmd_addr;
            beats   <= cmd_len;
            wr_pop  <= ~cmd_rw;
            if (!cmd_rw) begin
               wdata_q <= wr_data;
            end
         end

         if (next_beat) begin
            Valid   <= 1'b1;
            beats   <= beats - 8'd1;
            Addr_in <= Addr_in + 16'd1;
            wr_pop  <= ~RW;
            if (!RW) begin
               wdata_q <= wr_data;
            end
         end

         if (capture) begin
            Valid <= 1'b0;
            if (RW) begin
               rd_data  <= Data_in;
               rd_valid <= 1'b1;
            end
         end

         if (abort) begin
            Valid <= 1'b0;
            err   <= 1'b1;
         end

         if (finish) begin
            done <= 1'b1;
         end

         if (tmr_reload) begin
            tmr <= TMR_LOAD;
         end else if (tmr != '0) begin
            tmr <= tmr - TW'(1);
         end
      end
   end

   assign Data_in = (Valid && !RW) ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_master.sv
`timescale 1ns/1ps
module tb_mem_master;
   localparam int DW = 32;
   localparam int TO = 64;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_rw    = 1'b0;
   logic [15:0]   cmd_addr  = '0;
   logic [7:0]    cmd_len   = '0;
   logic [DW-1:0] wr_data;
   logic          wr_pop;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          done;
   logic          err;
   logic          Valid;
   logic          RW;
   logic [15:0]   Addr_in;
   tri   [DW-1:0] Data_in;
   logic          Ready     = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_master #(.DWIDTH(DW), .TIMEOUT(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_rw   (cmd_rw),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .wr_data  (wr_data),
      .wr_pop   (wr_pop),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .done     (done),
      .err      (err),
      .Valid    (Valid),
      .RW       (RW),
      .Addr_in  (Addr_in),
      .Data_in  (Data_in),
      .Ready    (Ready)
   );

   // Write-word source: presents wsrc[widx], advances on wr_pop.
   logic [DW-1:0] wsrc [4096];
   int            widx = 0;
   assign wr_data = wsrc[widx[11:0]];
   always @(posedge clk) if (wr_pop) widx <= widx + 1;

   // Controller + RAM model. mode 0: normal (Ready low busy_n cycles per
   // request, 0 = random 1..4), mode 1: Ready stuck high, mode 2: stuck low.
   int            ctrl_mode = 1;
   int            busy_n    = 2;
   logic          ctl_active = 1'b0;
   logic          ctl_served = 1'b0;
   int            ctl_cnt    = 0;
   logic [DW-1:0] mem [65536];
   assign Data_in = (Valid && RW) ? mem[Addr_in] : {DW{1'bz}};
   always @(posedge clk) begin
      if (ctrl_mode == 1 || ctrl_mode == 2) begin
         Ready      <= (ctrl_mode == 1);
         ctl_active <= 1'b0;
         ctl_served <= 1'b0;
      end else if (ctl_active) begin
         if (ctl_cnt > 1) ctl_cnt <= ctl_cnt - 1;
         else begin
            Ready      <= 1'b1;
            ctl_active <= 1'b0;
            ctl_served <= 1'b1;
            if (!RW) mem[Addr_in] <= Data_in;
         end
      end else if (Valid && !ctl_served) begin
         Ready      <= 1'b0;
         ctl_active <= 1'b1;
         ctl_cnt    <= (busy_n > 0) ? busy_n : int'($urandom_range(4, 1));
      end else if (!Valid) begin
         ctl_served <= 1'b0;
      end
   end

   // Bus monitor, sampled on the falling edge.
   typedef struct packed { logic rw; logic [15:0] addr; logic [DW-1:0] data; } req_t;
   req_t          req_q [$];
   int            gap_q [$];
   int            hi_q  [$];
   logic [DW-1:0] rd_q  [$];
   int            n_pop = 0, n_done = 0, n_err = 0, hold_viol = 0;
   int            high_run = 0, low_run = 0;
   logic          prev_valid = 1'b0, prev_rw = 1'b0;
   logic [15:0]   prev_addr = '0;
   logic [DW-1:0] prev_data = '0;
   always @(negedge clk) begin
      if (Valid && !prev_valid) begin
         req_q.push_back('{rw: RW, addr: Addr_in, data: Data_in});
         gap_q.push_back(low_run);
      end
      if (!Valid && prev_valid) hi_q.push_back(high_run);
      if (Valid) high_run <= prev_valid ? high_run + 1 : 1;
      else       low_run  <= prev_valid ? 1 : low_run + 1;
      if (Valid && prev_valid &&
          (Addr_in !== prev_addr || RW !== prev_rw || (!RW && Data_in !== prev_data)))
         hold_viol <= hold_viol + 1;
      if (wr_pop)   n_pop  <= n_pop + 1;
      if (done)     n_done <= n_done + 1;
      if (err)      n_err  <= n_err + 1;
      if (rd_valid) rd_q.push_back(rd_data);
      prev_valid <= Valid;
      prev_rw    <= RW;
      prev_addr  <= Addr_in;
      prev_data  <= Data_in;
   end

   // Reference memory: what the RAM must hold after completed write beats.
   logic [DW-1:0] ref_mem [int];

   function automatic logic [15:0] beat_addr(input logic [15:0] a, input int i);
      return a + 16'(i);
   endfunction

   task automatic put_word(input int i, input logic [DW-1:0] w);
      wsrc[12'(widx + i)] = w;
   endtask

   task automatic ctrl_set(input int m);
      ctrl_mode = m;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run_cmd(input logic rw, input logic [15:0] a, input logic [7:0] len,
                          output logic v_next, output logic got_done, output logic got_err);
      int k;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_len = len;
      k = 0;
      while (!cmd_ready && k < 500) begin @(negedge clk); k++; end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL accept_wait: cmd_ready=%0b, required 1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      v_next = Valid;
      k = 0;
      while (!(done || err) && k < 2000) begin @(negedge clk); k++; end
      got_done = done;
      got_err  = err;
      if (!(done || err)) begin
         checks++; errors++;
         $display("FAIL end_wait: no done/err within bound, done=%0b err=%0b", done, err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", Valid); end
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b, required 1", cmd_ready); end
      checks++;
      if ({wr_pop, rd_valid, done, err, RW} !== 5'b0)
         begin errors++; $display("FAIL reset_strobes: got %b, required 00000", {wr_pop, rd_valid, done, err, RW}); end
      checks++;
      if (Addr_in !== 16'h0 || rd_data !== '0)
         begin errors++; $display("FAIL reset_regs: Addr_in=%h rd_data=%h, required 0/0", Addr_in, rd_data); end
      reset = 1'b1;
      ctrl_set(0);
   endtask

   task automatic test_single_write();
      int b_req, b_pop, b_done, b_hv;
      logic vn, gd, ge;
      b_req = req_q.size(); b_pop = n_pop; b_done = n_done; b_hv = hold_viol;
      busy_n = 2;
      put_word(0, 32'hDEADBEEF);
      run_cmd(1'b0, 16'h0000, 8'd0, vn, gd, ge);
      ref_mem[0] = 32'hDEADBEEF;
      checks++;
      if (vn !== 1'b1) begin errors++; $display("FAIL sw_valid_next: got %0b, required 1", vn); end
      checks++;
      if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL sw_done: done=%0b err=%0b, required 1/0", gd, ge); end
      checks++;
      if (req_q.size() != b_req + 1) begin
         errors++; $display("FAIL sw_req_count: got %0d, required 1", req_q.size() - b_req);
      end else if (req_q[b_req].rw !== 1'b0 || req_q[b_req].addr !== 16'h0000 || req_q[b_req].data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL sw_req: rw=%0b addr=%h data=%h, required 0/0000/deadbeef",
                            req_q[b_req].rw, req_q[b_req].addr, req_q[b_req].data);
      end
      checks++;
      if (n_pop - b_pop != 1) begin errors++; $display("FAIL sw_pops: got %0d, required 1", n_pop - b_pop); end
      checks++;
      if (hi_q[hi_q.size()-1] != busy_n + 2)
         begin errors++; $display("FAIL sw_valid_len: got %0d, required %0d", hi_q[hi_q.size()-1], busy_n + 2); end
      checks++;
      if (mem[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_ram: got %h, required deadbeef", mem[0]); end
      checks++;
      if (hold_viol != b_hv || n_done - b_done != 1)
         begin errors++; $display("FAIL sw_hold_done: hold_viol=%0d done_pulses=%0d, required 0/1", hold_viol - b_hv, n_done - b_done); end
   endtask

   task automatic test_burst();
      int b_req, b_pop, b_done, b_rd;
      logic vn, gd, ge;
      logic [DW-1:0] w [3];
      w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
      b_req = req_q.size(); b_pop = n_pop; b_done = n_done; b_rd = rd_q.size();
      busy_n = 1;
      for (int i = 0; i < 3; i++) put_word(i, w[i]);
      run_cmd(1'b0, 16'h0000, 8'd2, vn, gd, ge);
      for (int i = 0; i < 3; i++) ref_mem[i] = w[i];
      run_cmd(1'b1, 16'h0000, 8'd2, vn, gd, ge);
      checks++;
      if (req_q.size() != b_req + 6) begin
         errors++; $display("FAIL burst_req_count: got %0d, required 6", req_q.size() - b_req);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (req_q[b_req+i].addr !== 16'(i % 3) || req_q[b_req+i].rw !== (i >= 3) ||
                (i < 3 && req_q[b_req+i].data !== w[i])) begin
               errors++; $display("FAIL burst_req%0d: rw=%0b addr=%h data=%h, required rw=%0b addr=%h",
                                  i, req_q[b_req+i].rw, req_q[b_req+i].addr, req_q[b_req+i].data, i >= 3, i % 3);
            end
            if (i % 3 != 0) begin
               checks++;
               if (gap_q[b_req+i] != 1) begin errors++; $display("FAIL burst_gap%0d: got %0d, required 1", i, gap_q[b_req+i]); end
            end
         end
      end
      checks++;
      if (n_pop - b_pop != 3 || n_done - b_done != 2)
         begin errors++; $display("FAIL burst_counts: pops=%0d done=%0d, required 3/2", n_pop - b_pop, n_done - b_done); end
      checks++;
      if (rd_q.size() != b_rd + 3) begin
         errors++; $display("FAIL burst_rd_count: got %0d, required 3", rd_q.size() - b_rd);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_q[b_rd+i] !== ref_mem[i]) begin errors++; $display("FAIL burst_rd%0d: got %h, required %h", i, rd_q[b_rd+i], ref_mem[i]); end
         end
      end
   endtask

   task automatic test_wrap();
      int b_req, b_rd;
      logic vn, gd, ge;
      logic [DW-1:0] w0, w1;
      w0 = $urandom; w1 = $urandom;
      busy_n = 0;
      put_word(0, w0); put_word(1, w1);
      b_req = req_q.size(); b_rd = rd_q.size();
      run_cmd(1'b0, 16'hFFFF, 8'd1, vn, gd, ge);
      ref_mem[16'hFFFF] = w0; ref_mem[16'h0000] = w1;
      run_cmd(1'b1, 16'hFFFF, 8'd1, vn, gd, ge);
      checks++;
      if (req_q.size() != b_req + 4) begin
         errors++; $display("FAIL wrap_req_count: got %0d, required 4", req_q.size() - b_req);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_q[b_req+i].addr !== beat_addr(16'hFFFF, i % 2))
               begin errors++; $display("FAIL wrap_addr%0d: got %h, required %h", i, req_q[b_req+i].addr, beat_addr(16'hFFFF, i % 2)); end
         end
      end
      checks++;
      if (rd_q.size() != b_rd + 2 || rd_q[b_rd] !== w0 || rd_q[b_rd+1] !== w1)
         begin errors++; $display("FAIL wrap_rd: got %0d words, required 2 words %h %h", rd_q.size() - b_rd, w0, w1); end
   endtask

   task automatic test_timeout();
      int b_pop, b_done, b_rd;
      logic vn, gd, ge;
      // Ready stuck high: abort after TO cycles of LAUNCH.
      ctrl_set(1);
      b_pop = n_pop; b_done = n_done;
      put_word(0, 32'hA5A5_0001);
      run_cmd(1'b0, 16'h0300, 8'd3, vn, gd, ge);
      checks++;
      if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("FAIL to_launch_err: err=%0b done=%0b, required 1/0", ge, gd); end
      checks++;
      if (hi_q[hi_q.size()-1] != TO) begin errors++; $display("FAIL to_launch_len: got %0d, required %0d", hi_q[hi_q.size()-1], TO); end
      checks++;
      if (Valid !== 1'b0 || cmd_ready !== 1'b1 || n_done != b_done || n_pop - b_pop != 1)
         begin errors++; $display("FAIL to_launch_after: Valid=%0b cmd_ready=%0b done=%0d pops=%0d, required 0/1/0/1",
                                  Valid, cmd_ready, n_done - b_done, n_pop - b_pop); end
      // Ready stuck low: one LAUNCH cycle then TO cycles of BUSY.
      ctrl_set(2);
      b_done = n_done; b_rd = rd_q.size();
      run_cmd(1'b1, 16'h0000, 8'd0, vn, gd, ge);
      checks++;
      if (ge !== 1'b1 || gd !== 1'b0) begin errors++; $display("FAIL to_busy_err: err=%0b done=%0b, required 1/0", ge, gd); end
      checks++;
      if (hi_q[hi_q.size()-1] != TO + 1) begin errors++; $display("FAIL to_busy_len: got %0d, required %0d", hi_q[hi_q.size()-1], TO + 1); end
      checks++;
      if (rd_q.size() != b_rd || n_done != b_done)
         begin errors++; $display("FAIL to_busy_after: rd=%0d done=%0d, required 0/0", rd_q.size() - b_rd, n_done - b_done); end
      ctrl_set(1);
      ctrl_set(0);
   endtask

   task automatic test_reset_mid();
      int b_req, b_pop, b_done, b_err, b_rd, k;
      logic vn, gd, ge;
      logic [DW-1:0] w [4];
      busy_n = 6;
      for (int i = 0; i < 4; i++) begin w[i] = $urandom; put_word(i, w[i]); end
      b_req = req_q.size(); b_pop = n_pop; b_done = n_done; b_err = n_err;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'h0100; cmd_len = 8'd3;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k = 0;
      while (req_q.size() < b_req + 2 && k < 500) begin @(negedge clk); k++; end
      checks++;
      if (req_q.size() < b_req + 2) begin errors++; $display("FAIL rm_reach_word2: got %0d requests, required 2", req_q.size() - b_req); end
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b0;
      ctrl_mode = 1;
      #1;
      checks++;
      if (Valid !== 1'b0 || cmd_ready !== 1'b1 || Addr_in !== 16'h0)
         begin errors++; $display("FAIL rm_async: Valid=%0b cmd_ready=%0b Addr_in=%h, required 0/1/0000", Valid, cmd_ready, Addr_in); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      ref_mem[16'h0100] = w[0];
      ctrl_set(0);
      checks++;
      if (n_done != b_done || n_err != b_err || n_pop - b_pop != 2)
         begin errors++; $display("FAIL rm_pulses: done=%0d err=%0d pops=%0d, required 0/0/2", n_done - b_done, n_err - b_err, n_pop - b_pop); end
      busy_n = 2;
      b_rd = rd_q.size();
      run_cmd(1'b1, 16'h0100, 8'd0, vn, gd, ge);
      checks++;
      if (gd !== 1'b1 || rd_q.size() != b_rd + 1 || rd_q[rd_q.size()-1] !== ref_mem[16'h0100])
         begin errors++; $display("FAIL rm_read_after: done=%0b rd=%h, required 1/%h", gd, rd_q[rd_q.size()-1], ref_mem[16'h0100]); end
   endtask

   task automatic test_back_to_back();
      int b_done, k;
      logic [DW-1:0] x;
      x = $urandom;
      busy_n = 1;
      put_word(0, x);
      b_done = n_done;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'h0200; cmd_len = 8'd0;
      @(posedge clk); #1;
      cmd_rw = 1'b1;
      k = 0;
      @(negedge clk);
      while (!done && k < 500) begin @(negedge clk); k++; end
      ref_mem[16'h0200] = x;
      checks++;
      if (done !== 1'b1 || cmd_ready !== 1'b1)
         begin errors++; $display("FAIL b2b_done_cycle: done=%0b cmd_ready=%0b, required 1/1", done, cmd_ready); end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (Valid !== 1'b1 || RW !== 1'b1 || Addr_in !== 16'h0200)
         begin errors++; $display("FAIL b2b_second_launch: Valid=%0b RW=%0b Addr_in=%h, required 1/1/0200", Valid, RW, Addr_in); end
      k = 0;
      while (!done && k < 500) begin @(negedge clk); k++; end
      @(posedge clk); #1;
      checks++;
      if (n_done - b_done != 2 || rd_q[rd_q.size()-1] !== ref_mem[16'h0200])
         begin errors++; $display("FAIL b2b_result: done=%0d rd=%h, required 2/%h", n_done - b_done, rd_q[rd_q.size()-1], ref_mem[16'h0200]); end
   endtask

   task automatic test_random();
      logic [15:0]   a;
      logic [7:0]    len;
      logic [DW-1:0] words [8];
      logic          vn, gd, ge;
      int            b_req, b_rd, n;
      busy_n = 0;
      for (int it = 0; it < 16; it++) begin
         a = 16'($urandom);
         if (it % 4 == 0) a = 16'hFFFF - 16'($urandom_range(3, 0));
         len = 8'($urandom_range(7, 0));
         n = int'(len) + 1;
         for (int i = 0; i < n; i++) begin words[i] = $urandom; put_word(i, words[i]); end
         b_req = req_q.size(); b_rd = rd_q.size();
         run_cmd(1'b0, a, len, vn, gd, ge);
         for (int i = 0; i < n; i++) ref_mem[int'(beat_addr(a, i))] = words[i];
         run_cmd(1'b1, a, len, vn, gd, ge);
         checks++;
         if (req_q.size() != b_req + 2 * n || rd_q.size() != b_rd + n) begin
            errors++; $display("FAIL rnd%0d_counts: req=%0d rd=%0d, required %0d/%0d",
                               it, req_q.size() - b_req, rd_q.size() - b_rd, 2 * n, n);
         end else begin
            for (int i = 0; i < n; i++) begin
               checks++;
               if (req_q[b_req+i].rw !== 1'b0 || req_q[b_req+i].addr !== beat_addr(a, i) || req_q[b_req+i].data !== words[i])
                  begin errors++; $display("FAIL rnd%0d_wr%0d: addr=%h data=%h, required %h/%h",
                                           it, i, req_q[b_req+i].addr, req_q[b_req+i].data, beat_addr(a, i), words[i]); end
               checks++;
               if (req_q[b_req+n+i].rw !== 1'b1 || req_q[b_req+n+i].addr !== beat_addr(a, i))
                  begin errors++; $display("FAIL rnd%0d_rdreq%0d: addr=%h, required %h", it, i, req_q[b_req+n+i].addr, beat_addr(a, i)); end
               checks++;
               if (rd_q[b_rd+i] !== ref_mem[int'(beat_addr(a, i))])
                  begin errors++; $display("FAIL rnd%0d_rd%0d: got %h, required %h", it, i, rd_q[b_rd+i], ref_mem[int'(beat_addr(a, i))]); end
               if (i > 0) begin
                  checks++;
                  if (gap_q[b_req+i] != 1 || gap_q[b_req+n+i] != 1)
                     begin errors++; $display("FAIL rnd%0d_gap%0d: got %0d/%0d, required 1/1", it, i, gap_q[b_req+i], gap_q[b_req+n+i]); end
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst();
      test_wrap();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      checks++;
      if (hold_viol != 0) begin errors++; $display("FAIL request_hold: %0d changes while Valid, required 0", hold_viol); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
